// File: rtl/sys_rst_pkg.sv
// Shared types and default timing constants for the system reset sequencer.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    DDR_CAL,
    RETRY,
    SYS_DLY,
    RUN,
    SW_RST,
    FAIL
  } rst_state_t;

  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_DDR_CALIB_TIMEOUT  = 1048576;
  localparam int DEF_SYS_DELAY_CYCLES   = 64;
  localparam int DEF_MAX_RETRIES        = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop level synchronizer; both stages clear to 0 on reset.
module cdc_sync2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/sys_rst_sequencer.sv
// Power-on reset sequencer: PLL reset/lock qualification, then DDR and system release.
// Define SYS_RST_SEQ_DDR_EN to build the DDR calibration, retry and failure path.
module sys_rst_sequencer
  import sys_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int DDR_CALIB_TIMEOUT  = DEF_DDR_CALIB_TIMEOUT,
  parameter int SYS_DELAY_CYCLES   = DEF_SYS_DELAY_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  input  logic       i_ddr_calib_done,
  input  logic       i_sw_reset,
  output logic       o_pll_reset,
  output logic       o_ddr_reset,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt
);

  localparam int MAXP = max_of(max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                      max_of(DDR_CALIB_TIMEOUT, SYS_DELAY_CYCLES)),
                               MAX_RETRIES);
  localparam int CW = $clog2(MAXP + 1);

  // Load values are N-1 so each state lasts exactly N cycles before its zero test fires.
  localparam logic [CW-1:0] LD_PLL  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOCK = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_SYS  = CW'(SYS_DELAY_CYCLES - 1);
`ifdef SYS_RST_SEQ_DDR_EN
  localparam logic [CW-1:0] LD_DDR  = CW'(DDR_CALIB_TIMEOUT - 1);
  localparam logic [1:0]    MAX_R   = 2'(MAX_RETRIES);
`endif

  rst_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_s;
  logic          pll_q, pll_d;
  logic          sys_q, sys_d;
  logic          ready_q, ready_d;

  cdc_sync2 u_lock_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_pll_locked),
    .o_q     (lock_s)
  );

`ifdef SYS_RST_SEQ_DDR_EN
  logic       ddr_q, ddr_d;
  logic       fail_q, fail_d;
  logic [1:0] retry_q, retry_d;
`else
  logic unused_calib_done;
  assign unused_calib_done = i_ddr_calib_done;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
`ifdef SYS_RST_SEQ_DDR_EN
    retry_d = retry_q;
`endif
    // Loss of lock is tested first so it outranks every other event in the same cycle.
    case (state_q)
      PLL_RST: if (cnt_q == '0) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (!lock_s)            cnt_d = LD_LOCK;
`ifdef SYS_RST_SEQ_DDR_EN
        else if (cnt_q == '0)   state_d = DDR_CAL;
`else
        else if (cnt_q == '0)   state_d = SYS_DLY;
`endif
      end
`ifdef SYS_RST_SEQ_DDR_EN
      DDR_CAL: begin
        if (!lock_s)                state_d = PLL_RST;
        else if (i_ddr_calib_done)  state_d = SYS_DLY;
        else if (cnt_q == '0)       state_d = RETRY;
      end
      RETRY: begin
        if (retry_q < MAX_R) begin
          retry_d = retry_q + 2'd1;
          state_d = PLL_RST;
        end else begin
          state_d = FAIL;
        end
      end
`endif
      SYS_DLY: begin
        if (!lock_s)           state_d = PLL_RST;
        else if (cnt_q == '0)  state_d = RUN;
      end
      RUN: begin
        if (!lock_s)           state_d = PLL_RST;
        else if (i_sw_reset)   state_d = SW_RST;
      end
      SW_RST: begin
        if (!lock_s)                         state_d = PLL_RST;
        else if (cnt_q == '0 && !i_sw_reset) state_d = RUN;
      end
      FAIL:    state_d = FAIL;
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        PLL_RST:          cnt_d = LD_PLL;
        WAIT_LOCK:        cnt_d = LD_LOCK;
`ifdef SYS_RST_SEQ_DDR_EN
        DDR_CAL:          cnt_d = LD_DDR;
`endif
        SYS_DLY, SW_RST:  cnt_d = LD_SYS;
        default:          cnt_d = '0;
      endcase
    end

    pll_d   = (state_d == PLL_RST);
    sys_d   = (state_d != RUN);
    ready_d = (state_d == RUN);
`ifdef SYS_RST_SEQ_DDR_EN
    ddr_d   = !(state_d inside {DDR_CAL, SYS_DLY, RUN, SW_RST});
    fail_d  = (state_d == FAIL);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PLL_RST;
      cnt_q   <= LD_PLL;
      pll_q   <= 1'b1;
      sys_q   <= 1'b1;
      ready_q <= 1'b0;
`ifdef SYS_RST_SEQ_DDR_EN
      ddr_q   <= 1'b1;
      fail_q  <= 1'b0;
      retry_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pll_q   <= pll_d;
      sys_q   <= sys_d;
      ready_q <= ready_d;
`ifdef SYS_RST_SEQ_DDR_EN
      ddr_q   <= ddr_d;
      fail_q  <= fail_d;
      retry_q <= retry_d;
`endif
    end
  end

  assign o_pll_reset = pll_q;
  assign o_sys_reset = sys_q;
  assign o_ready     = ready_q;
`ifdef SYS_RST_SEQ_DDR_EN
  assign o_ddr_reset = ddr_q;
  assign o_fail      = fail_q;
  assign o_retry_cnt = retry_q;
`else
  assign o_ddr_reset = 1'b1;
  assign o_fail      = 1'b0;
  assign o_retry_cnt = 2'd0;
`endif

endmodule

// File: doc/sys_rst_sequencer.md
# sys_rst_sequencer

Power-on reset sequencer downstream of the system PLL. It runs on the free-running board clock that also feeds the PLL. It drives the PLL reset and qualifies the asynchronous PLL lock indication, then releases the DDR controller and system resets in order, with DDR calibration timeout, PLL re-lock retries and loss-of-lock recovery. Consumer clock domains synchronize the reset levels they receive from this block.

## Interface
- PLL_RST_CYCLES, 16: cycles `o_pll_reset` is held high per attempt (≥2)
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before the lock is accepted
- DDR_CALIB_TIMEOUT, 1048576: maximum cycles spent waiting for `i_ddr_calib_done`
- SYS_DELAY_CYCLES, 64: cycles between DDR calibration done and `o_sys_reset` release
- MAX_RETRIES, 3: PLL re-lock attempts before declaring failure (1..3)
- i_clk  in  1  free-running board clock (PLL input clock)
- i_reset  in  1  reset, synchronous, active-high
- i_pll_locked  in  1  PLL lock, asynchronous to `i_clk`
- i_ddr_calib_done  in  1  DDR calibration complete, already synchronous to `i_clk`
- i_sw_reset  in  1  software system-reset request, level, synchronous
- o_pll_reset  out  1  PLL reset
- o_ddr_reset  out  1  DDR controller reset, active-high
- o_sys_reset  out  1  system reset, active-high
- o_ready  out  1  sequence complete, system running
- o_fail  out  1  sticky failure, cleared only by `i_reset`
- o_retry_cnt  out  2  PLL re-lock attempts used

## Operation
- `i_pll_locked` passes through a 2-flop synchronizer. `lock_s` is the synchronized output.
- One down-counter of width $clog2(max parameter + 1) is shared by all states and loaded on every state entry.
- PLL_RST: `o_pll_reset`=1. After PLL_RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: counter loaded with LOCK_STABLE_CYCLES.
  - `lock_s`=1 decrements the counter; `lock_s`=0 reloads it.
  - Counter reaches 0 → DDR_CAL.
  - No time limit in this state.
- DDR_CAL: `o_ddr_reset`=0, counter loaded with DDR_CALIB_TIMEOUT.
  - `i_ddr_calib_done`=1 → SYS_DLY.
  - Counter reaches 0 → RETRY.
- RETRY: `o_ddr_reset`=1.
  - If `o_retry_cnt` < MAX_RETRIES: increment `o_retry_cnt` → PLL_RST.
  - Otherwise → FAIL.
- SYS_DLY: after SYS_DELAY_CYCLES cycles → RUN.
- RUN: `o_sys_reset`=0, `o_ready`=1.
  - `i_sw_reset`=1 → SW_RST.
- SW_RST: `o_sys_reset`=1 for SYS_DELAY_CYCLES cycles, and additionally while `i_sw_reset` stays high, then → RUN. DDR stays out of reset.
- FAIL: `o_pll_reset`=0, `o_ddr_reset`=1, `o_sys_reset`=1, `o_fail`=1. Only `i_reset` leaves this state.
- Loss of lock: `lock_s`=0 in DDR_CAL, SYS_DLY, RUN or SW_RST → PLL_RST.
  - `o_retry_cnt` is not incremented.
  - All resets reassert on the next cycle.
- Loss of lock has priority over `i_sw_reset`, calibration done and timeout when they occur in the same cycle.
- `o_retry_cnt` saturates at MAX_RETRIES and is never reset by loss of lock.

## Timing
- Reset values:
  - `o_pll_reset`=1, `o_ddr_reset`=1, `o_sys_reset`=1
  - `o_ready`=0, `o_fail`=0, `o_retry_cnt`=0
  - state=PLL_RST, synchronizer flops=0
- All outputs are registered and decoded from the state register; no combinational path from inputs to outputs.
- Latency from `i_pll_locked` rising to DDR_CAL entry (lock continuously high): 2 + LOCK_STABLE_CYCLES cycles.
- Loss of lock: `o_sys_reset`/`o_ddr_reset` assert 3 cycles after `i_pll_locked` falls (2 sync + 1 state).
- `o_ready` deasserts in the same cycle that `o_sys_reset` asserts.
- `i_reset` mid-sequence restarts from PLL_RST on the next edge, with `o_retry_cnt` and `o_fail` cleared.

## Configuration
- `SYS_RST_SEQ_DDR_EN` defined: full sequence as above.
- `SYS_RST_SEQ_DDR_EN` undefined:
  - DDR_CAL and RETRY are not compiled.
  - WAIT_LOCK goes directly to SYS_DLY.
  - `o_ddr_reset` is tied to 1.
  - `i_ddr_calib_done` is ignored.
  - `o_retry_cnt` is tied to 0, and `o_fail` is tied to 0.

## Structure
- Shared package `sys_rst_pkg`:
  - state enum `rst_state_t` (PLL_RST, WAIT_LOCK, DDR_CAL, RETRY, SYS_DLY, RUN, SW_RST, FAIL)
  - default parameter constants
- Sub-module `cdc_sync2`: 2-flop synchronizer, reset to 0, reusable elsewhere.
- Counter and FSM stay in the top module.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, DDR_CALIB_TIMEOUT=32, SYS_DELAY_CYCLES=4, MAX_RETRIES=2.
- Nominal: lock high at cycle 10, calib_done at cycle 30 → `o_ddr_reset` falls at cycle 20, `o_sys_reset` falls and `o_ready` rises at cycle 34±1.
- Lock glitch: lock high for 5 cycles, low 1 cycle, then high → stable counter restarts, and `o_ddr_reset` stays 1 until 8 clean cycles have passed.
- Calibration never completes → two PLL_RST pulses of 4 cycles each, `o_retry_cnt` goes 1 then 2, then `o_fail`=1 with all resets high.
- Lock drops in RUN → `o_sys_reset`=1 and `o_ready`=0 exactly 3 cycles later, `o_pll_reset` pulses, full recovery follows, and `o_retry_cnt` is unchanged.
- `i_sw_reset` pulsed for 1 cycle in RUN → `o_sys_reset` high for 4 cycles, `o_ddr_reset` stays 0, `o_ready` returns to 1.
- `i_reset` asserted during DDR_CAL → all outputs return to reset values on the next edge; with macro undefined, the nominal run shows `o_ddr_reset` constant 1.
